lsq_fifo_hazard: RTL and testbench
==================================

Name: lsq_fifo_hazard

Overview:
- Parametrised circular-buffer load/store queue sitting between the address-generation stage and the data-cache interface in the exe stage.
- Generalises the fixed 8-entry queue:
  - configurable depth and field widths;
  - valid/ready handshake on both sides;
  - per-entry store tagging;
  - a combinational store-address hazard lookup used by the issue logic to hold younger loads that alias a queued store.

Parameters:
- NUM_ENTRIES, 8: queue depth; power of two, >= 2.
- ADDR_WIDTH, 40: address field width.
- DATA_WIDTH, 64: store data field width.
- CTRL_WIDTH, 15: opaque control field (instr_type, mem_size, rd packed by the producer).
- MATCH_LSB, 3: number of low address bits ignored by the hazard compare (8-byte granule).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous discard of all entries.
- in_valid_i  in  1  producer has an entry.
- in_ready_o  out  1  queue can accept an entry.
- in_addr_i  in  ADDR_WIDTH  entry address.
- in_data_i  in  DATA_WIDTH  entry data.
- in_ctrl_i  in  CTRL_WIDTH  entry control.
- in_is_store_i  in  1  entry is a store.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes the head.
- out_addr_o  out  ADDR_WIDTH  head address.
- out_data_o  out  DATA_WIDTH  head data.
- out_ctrl_o  out  CTRL_WIDTH  head control.
- out_is_store_o  out  1  head is a store.
- entry_o  out  clog2(NUM_ENTRIES)  slot index the next accepted entry will occupy (tail).
- count_o  out  clog2(NUM_ENTRIES)+1  occupancy.
- full_o  out  1  count_o == NUM_ENTRIES.
- empty_o  out  1  count_o == 0.
- chk_addr_i  in  ADDR_WIDTH  address to check for hazard.
- chk_hit_o  out  1  a queued store aliases chk_addr_i.

Behaviour:
- State:
  - head and tail pointers, clog2(NUM_ENTRIES) bits each; wrap modulo NUM_ENTRIES by natural overflow.
  - count register, clog2(NUM_ENTRIES)+1 bits.
  - per-slot valid and is_store bits; addr, data and ctrl arrays.
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = ~full_o & ~flush_i & ~rst_i. It does not depend on out_ready_i, so there is no combinational ready path.
  - out_valid_o = ~empty_o.
- Output path (first-word-fall-through):
  - out_* are driven combinationally from the head slot.
  - When out_valid_o = 0, out_addr_o, out_data_o, out_ctrl_o and out_is_store_o are forced to 0.
  - Push-to-visible latency is 1 cycle. There is no same-cycle bypass: an entry pushed into an empty queue appears at the output the next cycle.
- On push:
  - write slot[tail];
  - set valid[tail] and is_store[tail];
  - tail <= tail + 1.
- On pop:
  - clear valid[head];
  - head <= head + 1.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - push and pop in the same cycle with count == 1 is legal; writes and reads hit different slots.
  - In a full queue a pop does not enable a same-cycle push, because in_ready_o stays low.
- entry_o: equals tail, combinational.
- full_o / empty_o: decoded from count.
- Hazard check:
  - chk_hit_o = OR over all slots i of (valid[i] & is_store[i] & addr[i][ADDR_WIDTH-1:MATCH_LSB] == chk_addr_i[ADDR_WIDTH-1:MATCH_LSB]).
  - Purely combinational, reflecting current-cycle state.
  - Includes the head even if it pops this cycle.
  - Excludes an entry being pushed this cycle.
- Reset (rst_i = 1, registered) and flush (flush_i = 1), identical effect next cycle:
  - head = tail = 0, count = 0, all valid bits cleared.
  - Array contents are not cleared.
- Reset/flush priority:
  - Reset and flush have priority over push and pop in the same cycle; any pop in that cycle is discarded.
  - Producers must treat in_ready_o = 0 during reset/flush as a rejected push.
- Outputs after reset: out_valid_o = 0, out_* = 0, in_ready_o = 1 (once rst_i is low), entry_o = 0, count_o = 0, empty_o = 1, full_o = 0, chk_hit_o = 0.
- Reset in mid-operation: takes effect on the next edge regardless of occupancy; no partial drain.

Test Plan:
- Reset, then push addr 0x100/0x108/0x110 (loads) in 3 cycles with out_ready_i = 0 -> count_o 3, entry_o 3, head shows 0x100; then out_ready_i = 1 -> 0x100, 0x108, 0x110 on successive cycles, empty_o = 1 afterwards.
- Fill 8 entries -> full_o = 1, in_ready_o = 0; a 9th in_valid_i is not accepted; one pop -> in_ready_o = 1 next cycle; push wraps to tail 0, and entry_o reads 0 before that push.
- count 1 with simultaneous push and pop for 20 cycles, incrementing data -> count_o stays 1, output data strictly in order, pointers wrap twice.
- Store at 0x2008, load at 0x3000 queued; chk_addr_i 0x200C -> chk_hit_o = 1; 0x3000 -> 0 (load); 0x2010 -> 0; after the store pops -> 0x200C gives 0.
- 5 entries queued, flush_i with simultaneous push and pop -> next cycle count_o 0, empty_o 1, out_valid_o 0, out_* = 0, chk_hit_o 0, entry_o 0.
- rst_i asserted with 3 entries and in_valid_i = 1 -> in_ready_o = 0 that cycle; next cycle count_o 0, out_valid_o 0; deassert and push 0x40 -> visible one cycle later.

Source files
------------

// File: rtl/lsq_fifo_hazard_if.sv
// Load/store queue handshake bundle: producer-side push channel and
// consumer-side first-word-fall-through head channel.
interface lsq_fifo_hazard_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 15
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_is_store;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_is_store;

  // Producer (address generation) and consumer (data cache) side.
  modport master (
    output in_valid, in_addr, in_data, in_ctrl, in_is_store, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_ctrl, out_is_store
  );

  // The queue itself.
  modport slave (
    input  in_valid, in_addr, in_data, in_ctrl, in_is_store, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_ctrl, out_is_store
  );
endinterface

// File: rtl/lsq_fifo_hazard.sv
// Circular-buffer load/store queue between address generation and the data
// cache. Head is presented combinationally (one cycle push-to-visible, no
// bypass). A combinational lookup flags any queued store whose address
// aliases chk_addr_i at granule resolution, so issue can hold younger loads.
module lsq_fifo_hazard #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_WIDTH  = 40,
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = 15,
  parameter int MATCH_LSB   = 3,
  localparam int PW         = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  lsq_fifo_hazard_if.slave      bus,
  output logic [PW-1:0]         entry_o,
  output logic [PW:0]           count_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [ADDR_WIDTH-1:0] chk_addr_i,
  output logic                  chk_hit_o
);

  logic [PW-1:0]          head_q;
  logic [PW-1:0]          tail_q;
  logic [PW:0]            count_q;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] store_q;
  logic [ADDR_WIDTH-1:0]  addr_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];
  logic [CTRL_WIDTH-1:0]  ctrl_q [NUM_ENTRIES];

  logic push;
  logic pop;
  logic hit;

  assign full_o  = (count_q == (PW+1)'(NUM_ENTRIES));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign entry_o = tail_q;

  // in_ready never looks at out_ready, so a pop cannot open a slot for a
  // same-cycle push into a full queue.
  assign bus.in_ready  = ~full_o & ~flush_i & ~rst_i;
  assign bus.out_valid = ~empty_o;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.out_addr     = bus.out_valid ? addr_q[head_q] : '0;
  assign bus.out_data     = bus.out_valid ? data_q[head_q] : '0;
  assign bus.out_ctrl     = bus.out_valid ? ctrl_q[head_q] : '0;
  assign bus.out_is_store = bus.out_valid & store_q[head_q];

  // Pointers, occupancy and slot-valid bits; reset and flush win over push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage; contents are left stale on reset since valid gates use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q]  <= bus.in_addr;
      data_q[tail_q]  <= bus.in_data;
      ctrl_q[tail_q]  <= bus.in_ctrl;
      store_q[tail_q] <= bus.in_is_store;
    end
  end

  // Store-alias lookup over registered state only, ignoring the low granule bits.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && store_q[i] &&
          (((addr_q[i] ^ chk_addr_i) >> MATCH_LSB) == '0)) begin
        hit = 1'b1;
      end
    end
  end

  assign chk_hit_o = hit;

endmodule

// File: tb/tb_lsq_fifo_hazard.sv
// Directed bench for the load/store queue: handshake order, full/wrap,
// steady-state push+pop, store hazard lookup, flush and mid-run reset.
module tb_lsq_fifo_hazard;
  localparam int N  = 8;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int CW = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic [2:0]    entry_o;
  logic [3:0]    count_o;
  logic          full_o;
  logic          empty_o;
  logic [AW-1:0] chk_addr_i;
  logic          chk_hit_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  lsq_fifo_hazard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  lsq_fifo_hazard #(
    .NUM_ENTRIES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MATCH_LSB(3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .bus        (bus),
    .entry_o    (entry_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .chk_addr_i (chk_addr_i),
    .chk_hit_o  (chk_hit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    bus.in_ctrl     = '0;
    bus.in_is_store = 1'b0;
    bus.out_ready   = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [CW-1:0] c, input logic st);
    bus.in_valid    = 1'b1;
    bus.in_addr     = a;
    bus.in_data     = d;
    bus.in_ctrl     = c;
    bus.in_is_store = st;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_is_store = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_addr_i = '0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (entry_o !== 3'd0) $display("FAIL reset_entry got %0d want 0", entry_o); else pass_cnt++;
    total_cnt++; if (count_o !== 4'd0) $display("FAIL reset_count got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if (empty_o !== 1'b1 || full_o !== 1'b0) $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty_o, full_o); else pass_cnt++;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL reset_chk_hit got %b want 0", chk_hit_o); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== '0 || bus.out_data !== '0) $display("FAIL reset_out_zero got addr=%h data=%h want 0", bus.out_addr, bus.out_data); else pass_cnt++;
  endtask

  task automatic test_basic_order();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 40'h100; exp_a[1] = 40'h108; exp_a[2] = 40'h110;
    do_reset();
    for (int i = 0; i < 3; i++) push_one(exp_a[i], DW'(i + 1), CW'(i + 7), 1'b0);
    #1;
    total_cnt++; if (count_o !== 4'd3) $display("FAIL basic_count got %0d want 3", count_o); else pass_cnt++;
    total_cnt++; if (entry_o !== 3'd3) $display("FAIL basic_entry got %0d want 3", entry_o); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== 40'h100) $display("FAIL basic_head_hold got %h want 100", bus.out_addr); else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (bus.out_addr !== exp_a[i] || bus.out_ctrl !== CW'(i + 7) || bus.out_data !== DW'(i + 1))
        $display("FAIL basic_pop%0d got addr=%h ctrl=%h data=%h want %h %h %h", i, bus.out_addr, bus.out_ctrl, bus.out_data, exp_a[i], CW'(i + 7), DW'(i + 1));
      else pass_cnt++;
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    total_cnt++; if (empty_o !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL basic_empty got empty=%b valid=%b want 1 0", empty_o, bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < N; i++) push_one(AW'((i + 1) * 8), DW'(i), '0, 1'b0);
    #1;
    total_cnt++; if (full_o !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL full_flags got full=%b ready=%b want 1 0", full_o, bus.in_ready); else pass_cnt++;
    total_cnt++; if (count_o !== 4'd8) $display("FAIL full_count got %0d want 8", count_o); else pass_cnt++;
    push_one(40'hBAD, 64'hBAD, '0, 1'b0);
    #1;
    total_cnt++; if (count_o !== 4'd8) $display("FAIL full_reject_count got %0d want 8", count_o); else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1 || count_o !== 4'd7) $display("FAIL full_after_pop got ready=%b count=%0d want 1 7", bus.in_ready, count_o); else pass_cnt++;
    total_cnt++; if (entry_o !== 3'd0) $display("FAIL wrap_entry_before got %0d want 0", entry_o); else pass_cnt++;
    push_one(40'hAA8, 64'hAA8, '0, 1'b0);
    #1;
    total_cnt++; if (entry_o !== 3'd1 || full_o !== 1'b1) $display("FAIL wrap_entry_after got entry=%0d full=%b want 1 1", entry_o, full_o); else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= N; i++) begin
      logic [AW-1:0] want;
      want = (i < N) ? AW'((i + 1) * 8) : 40'hAA8;
      #1;
      total_cnt++; if (bus.out_addr !== want) $display("FAIL wrap_drain%0d got %h want %h", i, bus.out_addr, want); else pass_cnt++;
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL wrap_drain_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_one(40'h0, 64'd0, '0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_addr   = AW'(i * 8);
      bus.in_data   = DW'(i);
      bus.out_ready = 1'b1;
      #1;
      total_cnt++;
      if (bus.out_data !== DW'(i - 1) || count_o !== 4'd1)
        $display("FAIL b2b_step%0d got data=%0d count=%0d want %0d 1", i, bus.out_data, count_o, i - 1);
      else pass_cnt++;
      tick();
    end
    idle_inputs();
    #1;
    total_cnt++; if (bus.out_data !== 64'd20 || count_o !== 4'd1) $display("FAIL b2b_final got data=%0d count=%0d want 20 1", bus.out_data, count_o); else pass_cnt++;
    total_cnt++; if (entry_o !== 3'd5) $display("FAIL b2b_entry got %0d want 5", entry_o); else pass_cnt++;
  endtask

  task automatic test_hazard();
    do_reset();
    push_one(40'h2008, 64'h1, '0, 1'b1);
    push_one(40'h3000, 64'h2, '0, 1'b0);
    chk_addr_i = 40'h200C; #1;
    total_cnt++; if (chk_hit_o !== 1'b1) $display("FAIL haz_store_alias got %b want 1", chk_hit_o); else pass_cnt++;
    chk_addr_i = 40'h3000; #1;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL haz_load_ignored got %b want 0", chk_hit_o); else pass_cnt++;
    chk_addr_i = 40'h2010; #1;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL haz_next_granule got %b want 0", chk_hit_o); else pass_cnt++;
    chk_addr_i = 40'h2000; #1;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL haz_prev_granule got %b want 0", chk_hit_o); else pass_cnt++;
    chk_addr_i      = 40'h5000;
    bus.in_valid    = 1'b1;
    bus.in_addr     = 40'h5000;
    bus.in_is_store = 1'b1;
    #1;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL haz_push_excluded got %b want 0", chk_hit_o); else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total_cnt++; if (chk_hit_o !== 1'b1) $display("FAIL haz_pushed_visible got %b want 1", chk_hit_o); else pass_cnt++;
    chk_addr_i    = 40'h200C;
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (chk_hit_o !== 1'b1 || bus.out_is_store !== 1'b1) $display("FAIL haz_head_popping got hit=%b st=%b want 1 1", chk_hit_o, bus.out_is_store); else pass_cnt++;
    tick();
    bus.out_ready = 1'b0;
    #1;
    total_cnt++; if (chk_hit_o !== 1'b0) $display("FAIL haz_after_pop got %b want 0", chk_hit_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(AW'(40'h800 + i * 8), DW'(i + 100), 15'h1234, 1'b1);
    chk_addr_i = 40'h810; #1;
    total_cnt++; if (chk_hit_o !== 1'b1 || count_o !== 4'd5) $display("FAIL flush_pre got hit=%b count=%0d want 1 5", chk_hit_o, count_o); else pass_cnt++;
    flush_i       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 40'h900;
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", bus.in_ready); else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total_cnt++; if (count_o !== 4'd0 || empty_o !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL flush_state got count=%0d empty=%b valid=%b want 0 1 0", count_o, empty_o, bus.out_valid); else pass_cnt++;
    total_cnt++;
    if (bus.out_addr !== '0 || bus.out_data !== '0 || bus.out_ctrl !== '0 || bus.out_is_store !== 1'b0)
      $display("FAIL flush_out_zero got addr=%h data=%h ctrl=%h st=%b want 0", bus.out_addr, bus.out_data, bus.out_ctrl, bus.out_is_store);
    else pass_cnt++;
    total_cnt++; if (chk_hit_o !== 1'b0 || entry_o !== 3'd0) $display("FAIL flush_hit_entry got hit=%b entry=%0d want 0 0", chk_hit_o, entry_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(AW'(40'h700 + i * 8), DW'(i), '0, 1'b0);
    rst_i        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 40'h999;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", bus.in_ready); else pass_cnt++;
    tick();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    total_cnt++; if (count_o !== 4'd0 || bus.out_valid !== 1'b0) $display("FAIL rstmid_state got count=%0d valid=%b want 0 0", count_o, bus.out_valid); else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.in_addr  = 40'h40;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_no_bypass got %b want 0", bus.out_valid); else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 40'h40) $display("FAIL rstmid_visible got valid=%b addr=%h want 1 40", bus.out_valid, bus.out_addr); else pass_cnt++;
  endtask

  initial begin
    rst_i      = 1'b1;
    chk_addr_i = '0;
    idle_inputs();
    test_reset();
    test_basic_order();
    test_full_wrap();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
